// File: rtl/lcd_score_sched.sv
// lcd_score_sched: sole writer of an LCD character FIFO that draws two team
// scores. After reset it paints the static labels "A:" (line 1) and "B:"
// (line 2), then redraws a two-digit score field whenever a team reports a
// change. Every FIFO word is followed by at least GAP cycles with no write.
//
// Ports
//   CLK        block clock, also the FIFO write clock
//   RST        synchronous reset, active low
//   REQ_A/B    single-cycle "score changed" pulses
//   SCORE_A/B  7-bit binary scores, sampled when the frame is granted
//   LCD_WR_EN  one-cycle FIFO write strobe
//   LCD_DATA   FIFO word: bit 8 = RS (1 char, 0 command), bits 7:0 = byte
//   BUSY       high whenever the scheduler is not idle
module lcd_score_sched #(
  parameter int unsigned GAP   = 200,
  parameter logic [6:0]  POS_A = 7'h03,
  parameter logic [6:0]  POS_B = 7'h43
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [6:0] SCORE_A,
  input  logic [6:0] SCORE_B,
  output logic       LCD_WR_EN,
  output logic [8:0] LCD_DATA,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic        GAP_ZERO = (GAP == 0);
  // The gap counter runs GAP-1 .. 0, so the GAP state lasts exactly GAP cycles.
  localparam logic [11:0] GAP_M1   = (GAP == 0) ? 12'd0 : 12'(GAP - 1);
  localparam logic        TEAM_A   = 1'b0;
  localparam logic        TEAM_B   = 1'b1;

  function automatic logic [8:0] init_word(input logic [2:0] idx);
    logic [8:0] w;
    case (idx)
      3'd0:    w = 9'h080;
      3'd1:    w = 9'h141;
      3'd2:    w = 9'h13A;
      3'd3:    w = 9'h0C0;
      3'd4:    w = 9'h142;
      3'd5:    w = 9'h13A;
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  // Value is already saturated to 0..99 when it is latched.
  function automatic logic [8:0] frame_word(input logic [2:0] idx, input logic team,
                                            input logic [6:0] val);
    logic [6:0] tens;
    logic [6:0] units;
    logic [8:0] w;
    tens  = val / 7'd10;
    units = val - (tens * 7'd10);
    case (idx)
      3'd0:    w = {2'b01, ((team == TEAM_B) ? POS_B : POS_A)};
      3'd1:    w = (tens == 7'd0) ? 9'h120 : (9'h130 + {5'd0, tens[3:0]});
      3'd2:    w = 9'h130 + {5'd0, units[3:0]};
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] word_q, word_d;
  logic       init_q, init_d;
  logic       team_q, team_d;
  logic [6:0] val_q, val_d;
  logic [11:0] cnt_q, cnt_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic       last_q, last_d;
  logic       wr_en_q, wr_en_d;
  logic [8:0] data_q, data_d;
  logic       busy_q, busy_d;

  logic       adv_s;
  logic       last_word_s;
  logic       eff_pa_s;
  logic       eff_pb_s;
  logic       grant_now_s;
  logic       gnt_team_s;
  logic [2:0] nxt_word_s;

  // Grant arbitration: decision point is IDLE or the end of the last gap of a frame.
  always_comb begin
    nxt_word_s  = word_q + 3'd1;
    last_word_s = init_q ? (word_q == 3'd5) : (word_q == 3'd2);
    adv_s       = ((state_q == S_SEND) && GAP_ZERO) ||
                  ((state_q == S_GAP) && (cnt_q == 12'd0));
    // Finishing the label sequence makes both score fields pending.
    eff_pa_s    = pend_a_q | (adv_s & last_word_s & init_q);
    eff_pb_s    = pend_b_q | (adv_s & last_word_s & init_q);
    if (eff_pa_s && eff_pb_s) begin
      gnt_team_s = ~last_q;
    end else begin
      gnt_team_s = eff_pb_s ? TEAM_B : TEAM_A;
    end
    grant_now_s = (eff_pa_s | eff_pb_s) &&
                  ((state_q == S_IDLE) || (adv_s && last_word_s));
  end

  // Next-state, next-word and output register inputs.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    init_d  = init_q;
    team_d  = team_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_en_d = 1'b0;
    data_d  = data_q;
    if (grant_now_s) begin
      state_d = S_SEND;
      wr_en_d = 1'b1;
      data_d  = frame_word(3'd0, gnt_team_s, 7'd0);
      word_d  = 3'd0;
      init_d  = 1'b0;
      team_d  = gnt_team_s;
      last_d  = gnt_team_s;
      val_d   = sat99((gnt_team_s == TEAM_B) ? SCORE_B : SCORE_A);
    end else if (adv_s && !last_word_s) begin
      state_d = S_SEND;
      wr_en_d = 1'b1;
      word_d  = nxt_word_s;
      data_d  = init_q ? init_word(nxt_word_s) : frame_word(nxt_word_s, team_q, val_q);
    end else if (adv_s) begin
      state_d = S_IDLE;
      init_d  = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_d = S_SEND;
          wr_en_d = 1'b1;
          init_d  = 1'b1;
          data_d  = init_word(word_q);
        end
        S_SEND: begin
          state_d = S_GAP;
          cnt_d   = GAP_M1;
        end
        S_GAP:   cnt_d   = cnt_q - 12'd1;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Pending flags: a request at the same edge as a grant clear wins.
  always_comb begin
    pend_a_d = REQ_A | (eff_pa_s & ~(grant_now_s & (gnt_team_s == TEAM_A)));
    pend_b_d = REQ_B | (eff_pb_s & ~(grant_now_s & (gnt_team_s == TEAM_B)));
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_INIT;
      word_q   <= 3'd0;
      init_q   <= 1'b1;
      team_q   <= TEAM_A;
      val_q    <= 7'd0;
      cnt_q    <= 12'd0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      last_q   <= TEAM_B;
      wr_en_q  <= 1'b0;
      data_q   <= 9'h000;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      init_q   <= init_d;
      team_q   <= team_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      last_q   <= last_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign LCD_WR_EN = wr_en_q;
  assign LCD_DATA  = data_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/lcd_score_sched.md
LCD_SCORE_SCHED -- requirements
Module: lcd_score_sched

Interface
REQ-001 Parameter GAP, default 200: minimum number of CLK cycles with LCD_WR_EN low after every write pulse.
REQ-002 Parameter POS_A, default 7'h03: DDRAM address of the team A score field (line 1).
REQ-003 Parameter POS_B, default 7'h43: DDRAM address of the team B score field (line 2).
REQ-004 CLK  input  1  single block clock; also drives the LCD character FIFO write port (CLK_WR).
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 REQ_A  input  1  single-cycle pulse: team A score changed.
REQ-007 REQ_B  input  1  single-cycle pulse: team B score changed.
REQ-008 SCORE_A  input  7  team A score, binary.
REQ-009 SCORE_B  input  7  team B score, binary.
REQ-010 LCD_WR_EN  output  1  one-cycle write strobe into the LCD character FIFO.
REQ-011 LCD_DATA  output  9  FIFO word: bit 8 = RS (1 character, 0 command), bits 7:0 = byte.
REQ-012 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block shall be the sole writer of the LCD character FIFO and shall never issue two writes less than GAP+1 cycles apart.
REQ-014 States: INIT, IDLE, SEND, GAP; all outputs and state registered.
REQ-015 INIT shall emit, in order: 9'h080, 9'h141 'A', 9'h13A ':', 9'h0C0, 9'h142 'B', 9'h13A ':', with a GAP phase after each word.
REQ-016 On INIT completion, pending_A and pending_B shall both be set, so both score fields are drawn.
REQ-017 A REQ_x high at a rising edge shall set pending_x; a set and a grant clear of the same flag at the same edge leave it set (set wins).
REQ-018 In IDLE with any pending flag, the block shall grant at the next edge: one pending -> that one; both -> the team not granted last (round-robin, last_grant resets to B, so A wins the first tie).
REQ-019 On grant: clear the pending flag, latch the granted SCORE_x, record last_grant, enter SEND; later SCORE_x changes do not affect the frame in flight.
REQ-020 A SEND frame is three words: 9'h080|POS_x (set address), tens character, units character; a GAP phase follows each word.
REQ-021 Digit rules: latched value >99 saturates to 99; tens = v/10, units = v%10; tens character 9'h130+tens, except tens=0 gives 9'h120 (blank); units character 9'h130+units.
REQ-022 Latency: REQ_x high in cycle k with block IDLE -> first LCD_WR_EN high in cycle k+2.
REQ-023 LCD_WR_EN shall be high for exactly one cycle per word; LCD_DATA is valid in that cycle and holds its value otherwise.
REQ-024 After the last GAP of a frame, the block shall return to IDLE; with a flag still pending, the next grant follows immediately (no extra wait beyond GAP).
REQ-025 A REQ_x for the team currently in SEND shall cause a second full frame for that team after the current one, using the value sampled at that grant.
REQ-026 Multiple REQ_x pulses while pending_x is set shall collapse into one frame.
REQ-027 The GAP counter shall be wide enough for GAP up to 4095; GAP=0 permits back-to-back writes.

Reset
REQ-028 While RST is low at a rising edge: state <= INIT (word 0), pending flags <= 0, last_grant <= B, gap counter <= 0, LCD_WR_EN <= 0, LCD_DATA <= 9'h000, BUSY <= 1.
REQ-029 Reset asserted mid-frame shall abort the frame at the next edge without a further write; REQ_x pulses coincident with reset are discarded.
REQ-030 The first INIT write shall occur in the first cycle after RST is released.

Verification
REQ-031 Release reset, SCORE_A=5, SCORE_B=12, GAP=3 -> 12 writes: 080,141,13A,0C0,142,13A,083,120,135,0C3,131,132, each separated by exactly 3 idle cycles, then BUSY=0.
REQ-032 Idle, SCORE_A=99, pulse REQ_A in cycle k -> LCD_WR_EN in cycle k+2 with 083, then 139, 139.
REQ-033 SCORE_B=127, pulse REQ_B -> 0C3, 139, 139 (saturation).
REQ-034 REQ_A and REQ_B pulsed in the same cycle with last_grant=A -> B frame first, then A frame; pulse REQ_A again during A frame -> exactly one additional A frame.
REQ-035 Assert RST during the second word of a frame -> no further write in that frame; the INIT sequence restarts from 080 after release.
REQ-036 Throughout all tests, assert no two LCD_WR_EN pulses closer than GAP+1 cycles and no LCD_WR_EN wider than 1 cycle.
